// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package uart_arb_pkg;

    localparam int UART_BYTE_W = 8;

    // Arbiter FSM encoding; values are fixed so waveforms decode the same everywhere.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCEPT = 3'd1,
        STROBE = 3'd2,
        GUARD  = 3'd3,
        DRAIN  = 3'd4
    } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and buart-facing signal bundle for uart_tx_arbiter.
// Latency: none (wires only).
// Backpressure: req_ready carries it back to the requesters; uart_busy stalls the arbiter.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    import uart_arb_pkg::*;

    logic [NUM_REQ-1:0]             req_valid;
    logic [UART_BYTE_W*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]             req_last;
    logic [NUM_REQ-1:0]             req_ready;
    logic [NUM_REQ-1:0]             grant;
    logic                           uart_wr;
    logic [UART_BYTE_W-1:0]         uart_tx_data;
    logic                           uart_busy;
    logic                           timeout_err;

    // Requesters plus the buart: they drive bytes and busy, observe grant and strobe.
    modport master (
        output req_valid, req_data, req_last, uart_busy,
        input  req_ready, grant, uart_wr, uart_tx_data, timeout_err
    );

    // The arbiter itself.
    modport slave (
        input  req_valid, req_data, req_last, uart_busy,
        output req_ready, grant, uart_wr, uart_tx_data, timeout_err
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after the pointer, wrapping.
// Latency: purely combinational.
// Backpressure: none; win_o is zero when no request is set.
module uart_tx_arbiter_rr_pick #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  win_o,
    output logic [IW-1:0] idx_o
);

    logic [N-1:0]  rot;
    logic [IW-1:0] off;
    logic [IW:0]   sum;
    logic          found;

    // Rotate the doubled request vector so the pointer lands on bit 0, take the
    // lowest set bit, then add the pointer back modulo N to recover the index.
    always_comb begin
        rot   = N'({req_i, req_i} >> ptr_i);
        found = 1'b0;
        off   = '0;
        for (int j = 0; j < N; j++) begin
            if (!found && rot[j]) begin
                found = 1'b1;
                off   = IW'(j);
            end
        end
        sum = {1'b0, ptr_i} + {1'b0, off};
        if (sum >= (IW+1)'(N)) begin
            sum = sum - (IW+1)'(N);
        end
        idx_o = sum[IW-1:0];
        win_o = found ? (N'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one buart transmitter among NUM_REQ byte streams, round-robin, locked per packet.
// Latency: handshake at cycle t gives uart_wr at t+1; at least 4 cycles per byte plus busy time.
// Backpressure: req_ready only in ACCEPT with busy low; optional UART_ARB_TIMEOUT_EN abandons stalled packets.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic             clk,
    input  logic             reset,
    uart_tx_arbiter_if.slave bus
);

    localparam int IW = $clog2(NUM_REQ);

    // Reject configurations the picker and counter are not built for.
    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("uart_tx_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    arb_state_e             state_q, state_d;
    logic [NUM_REQ-1:0]     grant_q, grant_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [IW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [UART_BYTE_W-1:0] data_q, data_d;
    logic                   last_q, last_d;

    logic [NUM_REQ-1:0]     win;
    logic [IW-1:0]          win_idx;
    logic [NUM_REQ-1:0]     ready;
    logic                   hs;
    logic [IW-1:0]          next_ptr;
    logic [UART_BYTE_W-1:0] sel_data;
    logic                   sel_last;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             to_err_q, to_err_d;
`endif

    uart_tx_arbiter_rr_pick #(.N(NUM_REQ)) u_rr_pick (
        .req_i (bus.req_valid),
        .ptr_i (rr_ptr_q),
        .win_o (win),
        .idx_o (win_idx)
    );

    // Only the owner may hand over a byte, and only when the buart can take one.
    assign ready    = {NUM_REQ{(state_q == ACCEPT) && !bus.uart_busy}} & grant_q & bus.req_valid;
    assign hs       = |ready;
    // The pointer moves past the owner so a chatty requester cannot starve the others.
    assign next_ptr = (idx_q == IW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;

    assign bus.req_ready    = ready;
    assign bus.grant        = grant_q;
    assign bus.uart_wr      = (state_q == STROBE);
    assign bus.uart_tx_data = data_q;
`ifdef UART_ARB_TIMEOUT_EN
    assign bus.timeout_err  = to_err_q;
`else
    assign bus.timeout_err  = 1'b0;
`endif

    // Mux the granted requester's byte and last tag out of the packed buses.
    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                sel_data = bus.req_data[i*UART_BYTE_W +: UART_BYTE_W];
                sel_last = bus.req_last[i];
            end
        end
    end

    // Next-state logic: grant, accept one byte, strobe, wait out busy, repeat until last.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        idx_d    = idx_q;
        rr_ptr_d = rr_ptr_q;
        data_d   = data_q;
        last_d   = last_q;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d    = cnt_q;
        to_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (|bus.req_valid) begin
                    grant_d = win;
                    idx_d   = win_idx;
                    state_d = ACCEPT;
`ifdef UART_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ACCEPT: begin
                if (hs) begin
                    data_d  = sel_data;
                    last_d  = sel_last;
                    state_d = STROBE;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (cnt_q == TO_LAST) begin
                    // Owner went quiet mid-packet: drop the lock and let others in.
                    to_err_d = 1'b1;
                    grant_d  = '0;
                    rr_ptr_d = next_ptr;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            STROBE: state_d = GUARD;
            // buart raises busy a cycle after wr, so busy is not trusted here.
            GUARD:  state_d = DRAIN;
            DRAIN: begin
                if (!bus.uart_busy) begin
                    if (last_q) begin
                        grant_d  = '0;
                        rr_ptr_d = next_ptr;
                        state_d  = IDLE;
                    end else begin
                        state_d  = ACCEPT;
`ifdef UART_ARB_TIMEOUT_EN
                        cnt_d    = '0;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, grant and captured-byte registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            idx_q    <= '0;
            rr_ptr_q <= '0;
            data_q   <= '0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            idx_q    <= idx_d;
            rr_ptr_q <= rr_ptr_d;
            data_q   <= data_d;
            last_q   <= last_d;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    // Stall counter and the one-cycle abandon pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            to_err_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            to_err_q <= to_err_d;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a buart stub (busy 1 cycle after wr, held 20 cycles).
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_tx_arbiter;

    localparam int NR = 4;
    localparam int TO = 50;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(NR)) bif ();

    uart_tx_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bif)
    );

    int checks = 0;
    int errors = 0;

    // Per-requester byte rings: {last, data}.
    logic [8:0] rbuf [NR][16];
    int rhead [NR] = '{default: 0};
    int rtail [NR] = '{default: 0};

    logic [7:0] exp_q [$];
    int   wr_count   = 0;
    int   stub_cnt   = 0;
    logic force_busy = 1'b0;

    assign bif.uart_busy = (stub_cnt != 0) || force_busy;

    // buart stub: busy from the cycle after wr for 20 cycles.
    always @(posedge clk) begin
        if (bif.uart_wr === 1'b1) stub_cnt <= 20;
        else if (stub_cnt > 0)    stub_cnt <= stub_cnt - 1;
    end

    // Scoreboard: every strobe must carry the next expected byte and never hit a busy buart.
    always @(posedge clk) begin
        if (bif.uart_wr === 1'b1) begin
            wr_count++;
            checks++;
            if (bif.uart_busy !== 1'b0) begin
                errors++;
                $display("FAIL wr_while_busy: busy=%b required 0", bif.uart_busy);
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_byte: got %h, none expected", bif.uart_tx_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (bif.uart_tx_data !== e) begin
                    errors++;
                    $display("FAIL byte_order: got %h required %h", bif.uart_tx_data, e);
                end
            end
        end
    end

    // Consume a ring entry on handshake.
    always @(posedge clk) begin
        for (int i = 0; i < NR; i++)
            if (bif.req_valid[i] && bif.req_ready[i] === 1'b1) rhead[i] = rhead[i] + 1;
    end

    // Present the head of each ring away from the clock edge.
    always @(negedge clk) begin
        logic [NR-1:0]   v, l;
        logic [8*NR-1:0] d;
        v = '0; l = '0; d = '0;
        for (int i = 0; i < NR; i++) begin
            if (rhead[i] != rtail[i]) begin
                v[i]         = 1'b1;
                d[i*8 +: 8]  = rbuf[i][rhead[i] % 16][7:0];
                l[i]         = rbuf[i][rhead[i] % 16][8];
            end
        end
        bif.req_valid = v;
        bif.req_data  = d;
        bif.req_last  = l;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic l, input bit expect_out);
        rbuf[r][rtail[r] % 16] = {l, d};
        rtail[r] = rtail[r] + 1;
        if (expect_out) exp_q.push_back(d);
    endtask

    // Run until everything pending is sent and the arbiter is idle; count stray ready bits.
    task automatic run_until_idle(input int maxc, output bit ok, output int stray);
        bit empty;
        ok = 1'b0;
        stray = 0;
        for (int c = 0; c < maxc; c++) begin
            tick;
            if ((bif.req_ready & ~bif.grant) != 0 || $countones(bif.req_ready) > 1) stray++;
            empty = 1'b1;
            for (int i = 0; i < NR; i++) if (rhead[i] != rtail[i]) empty = 1'b0;
            if (empty && exp_q.size() == 0 && bif.grant == 0 && !bif.uart_busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) tick;
        checks++; if (bif.grant !== 4'b0)       begin errors++; $display("FAIL rst_grant: %b required 0000", bif.grant); end
        checks++; if (bif.req_ready !== 4'b0)   begin errors++; $display("FAIL rst_ready: %b required 0000", bif.req_ready); end
        checks++; if (bif.uart_wr !== 1'b0)     begin errors++; $display("FAIL rst_wr: %b required 0", bif.uart_wr); end
        checks++; if (bif.uart_tx_data !== 8'h0) begin errors++; $display("FAIL rst_data: %h required 00", bif.uart_tx_data); end
        checks++; if (bif.timeout_err !== 1'b0) begin errors++; $display("FAIL rst_timeout: %b required 0", bif.timeout_err); end
        rst = 1'b0;
        tick;
    endtask

    task automatic test_single_byte;
        int n, wc0;
        wc0 = wr_count;
        push(0, 8'h41, 1'b1, 1'b1);
        n = 0;
        while (bif.grant == 0 && n < 20) begin tick; n++; end
        checks++; if (n != 1)                   begin errors++; $display("FAIL t1_grant_latency: %0d cycles required 1", n); end
        checks++; if (bif.grant !== 4'b0001)    begin errors++; $display("FAIL t1_grant: %b required 0001", bif.grant); end
        checks++; if (bif.req_ready !== 4'b0001) begin errors++; $display("FAIL t1_ready: %b required 0001", bif.req_ready); end
        tick;
        checks++; if (bif.uart_wr !== 1'b1 || bif.uart_tx_data !== 8'h41) begin
            errors++; $display("FAIL t1_strobe: wr=%b data=%h required 1/41", bif.uart_wr, bif.uart_tx_data);
        end
        n = 0;
        while (bif.grant != 0 && n < 100) begin tick; n++; end
        checks++; if (bif.grant !== 4'b0 || bif.uart_busy !== 1'b0) begin
            errors++; $display("FAIL t1_release: grant=%b busy=%b required 0000/0", bif.grant, bif.uart_busy);
        end
        checks++; if (wr_count - wc0 != 1) begin errors++; $display("FAIL t1_wr_count: %0d required 1", wr_count - wc0); end
    endtask

    task automatic test_packet_lock;
        bit ok; int stray;
        push(1, 8'h10, 1'b0, 1'b1);
        push(1, 8'h11, 1'b0, 1'b1);
        push(1, 8'h12, 1'b1, 1'b1);
        push(2, 8'h20, 1'b1, 1'b1);
        run_until_idle(400, ok, stray);
        checks++; if (!ok)        begin errors++; $display("FAIL t2_done: timed out, %0d bytes left", exp_q.size()); end
        checks++; if (stray != 0) begin errors++; $display("FAIL t2_ready_lock: %0d stray ready samples required 0", stray); end
    endtask

    task automatic test_round_robin;
        bit ok; int stray;
        // One packet from req1 leaves the pointer at 2.
        push(1, 8'h99, 1'b1, 1'b1);
        run_until_idle(100, ok, stray);
        checks++; if (!ok) begin errors++; $display("FAIL t3_setup: timed out"); end
        for (int i = 0; i < NR; i++) push(i, 8'hA0 + 8'(i), 1'b1, 1'b0);
        exp_q.push_back(8'hA2); exp_q.push_back(8'hA3);
        exp_q.push_back(8'hA0); exp_q.push_back(8'hA1);
        tick;
        checks++; if (bif.grant !== 4'b0100) begin errors++; $display("FAIL t3_first_grant: %b required 0100", bif.grant); end
        run_until_idle(600, ok, stray);
        checks++; if (!ok)        begin errors++; $display("FAIL t3_done: timed out, %0d bytes left", exp_q.size()); end
        checks++; if (stray != 0) begin errors++; $display("FAIL t3_ready: %0d stray ready samples required 0", stray); end
    endtask

    task automatic test_busy_respect;
        bit ok; int stray, viol;
        force_busy = 1'b1;
        push(2, 8'h77, 1'b1, 1'b1);
        tick;
        checks++; if (bif.grant !== 4'b0100) begin errors++; $display("FAIL t4_grant: %b required 0100", bif.grant); end
        viol = 0;
        for (int c = 0; c < 15; c++) begin
            tick;
            if (bif.req_ready != 0 || bif.uart_wr != 0) viol++;
        end
        checks++; if (viol != 0) begin errors++; $display("FAIL t4_hold: %0d samples with ready/wr under busy required 0", viol); end
        force_busy = 1'b0;
        tick;
        checks++; if (bif.uart_wr !== 1'b1) begin errors++; $display("FAIL t4_resume: wr=%b required 1", bif.uart_wr); end
        run_until_idle(100, ok, stray);
        checks++; if (!ok) begin errors++; $display("FAIL t4_done: timed out"); end
    endtask

    task automatic test_reset_mid_packet;
        bit ok; int stray, n, seen;
        push(2, 8'h31, 1'b0, 1'b1);
        push(2, 8'h32, 1'b0, 1'b1);
        push(2, 8'h33, 1'b1, 1'b0);
        tick;
        checks++; if (bif.grant !== 4'b0100) begin errors++; $display("FAIL t5_grant: %b required 0100", bif.grant); end
        push(0, 8'h55, 1'b1, 1'b1);
        seen = 0; n = 0;
        while (seen < 2 && n < 200) begin tick; n++; if (bif.uart_wr === 1'b1) seen++; end
        checks++; if (seen != 2) begin errors++; $display("FAIL t5_two_bytes: %0d strobes required 2", seen); end
        tick; tick;  // GUARD, then DRAIN of byte 2
        rst = 1'b1;
        rhead[2] = rtail[2];
        tick;
        checks++; if (bif.grant !== 4'b0 || bif.uart_wr !== 1'b0 || bif.req_ready !== 4'b0) begin
            errors++; $display("FAIL t5_reset: grant=%b wr=%b ready=%b required 0000/0/0000", bif.grant, bif.uart_wr, bif.req_ready);
        end
        tick;
        rst = 1'b0;
        n = 0;
        while (bif.grant == 0 && n < 60) begin tick; n++; end
        checks++; if (bif.grant !== 4'b0001) begin errors++; $display("FAIL t5_regrant: %b required 0001", bif.grant); end
        run_until_idle(100, ok, stray);
        checks++; if (!ok) begin errors++; $display("FAIL t5_done: timed out, %0d bytes left", exp_q.size()); end
    endtask

`ifdef UART_ARB_TIMEOUT_EN
    task automatic test_timeout;
        bit ok; int stray, n, k, pulses;
        push(3, 8'h66, 1'b0, 1'b1);
        tick;
        checks++; if (bif.grant !== 4'b1000) begin errors++; $display("FAIL t6_grant: %b required 1000", bif.grant); end
        push(1, 8'h88, 1'b1, 1'b1);
        n = 0;
        while (bif.uart_wr !== 1'b1 && n < 20) begin tick; n++; end
        tick;
        n = 0;
        while (bif.uart_busy && n < 60) begin tick; n++; end
        k = 0; pulses = 0;
        while (bif.timeout_err !== 1'b1 && k < 200) begin tick; k++; end
        checks++; if (k != TO + 1) begin errors++; $display("FAIL t6_timeout_delay: %0d cycles required %0d", k, TO + 1); end
        checks++; if (bif.grant !== 4'b0) begin errors++; $display("FAIL t6_drop_grant: %b required 0000", bif.grant); end
        for (int c = 0; c < 5; c++) begin
            if (bif.timeout_err === 1'b1) pulses++;
            tick;
            if (c == 0) begin
                checks++; if (bif.grant !== 4'b0010) begin errors++; $display("FAIL t6_next_grant: %b required 0010", bif.grant); end
            end
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL t6_pulse_width: %0d cycles required 1", pulses); end
        run_until_idle(100, ok, stray);
        checks++; if (!ok) begin errors++; $display("FAIL t6_done: timed out"); end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_single_byte;
        test_packet_lock;
        test_round_robin;
        test_busy_respect;
        test_reset_mid_packet;
`ifdef UART_ARB_TIMEOUT_EN
        test_timeout;
`endif
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_empty: %0d left required 0", exp_q.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
